mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles waited for mem_gnt or mem_rvalid before a bus error is declared.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (ALU stage) has an operation.
REQ-005 in_ready  output  1  stage accepts the operation this cycle.
REQ-006 in_opcode  input  6  instruction[31:26] of the operation.
REQ-007 in_result  input  32  ALU result, used as write-back data or memory address.
REQ-008 in_store_data  input  32  rt value for Sw.
REQ-009 in_dest  input  5  destination register index.
REQ-010 in_flags  input  3  ALU flags: bit2 overflow, bit1 less-than, bit0 equal.
REQ-011 mem_req  output  1  memory request; held until granted.
REQ-012 mem_we  output  1  1 = store, 0 = load.
REQ-013 mem_addr  output  32  word address (registered in_result).
REQ-014 mem_wdata  output  32  store data.
REQ-015 mem_gnt  input  1  request accepted this cycle.
REQ-016 mem_rvalid  input  1  load data valid this cycle.
REQ-017 mem_rdata  input  32  load data.
REQ-018 wb_valid  output  1  write-back record valid.
REQ-019 wb_ready  input  1  downstream accepts the record.
REQ-020 wb_we  output  1  register-file write enable.
REQ-021 wb_dest  output  5  register index.
REQ-022 wb_data  output  32  write-back value.
REQ-023 wb_exc  output  2  00 none, 01 overflow, 10 misaligned, 11 bus timeout.

Function
REQ-024 States SHALL be IDLE, REQ, WAIT_RD, OUT.
REQ-025 in_ready SHALL be 1 in IDLE, and in OUT when wb_ready is 1; otherwise 0. A transfer occurs when in_valid and in_ready are both 1.
REQ-026 On transfer, opcode, result, store data, dest and flags SHALL be registered; in_* values are ignored at all other times.
REQ-027 Non-memory op: go to OUT next cycle; wb_data = result; wb_we = 1 unless the op is Sw, Beq or Bne, or flags[2] = 1 (wb_exc = 01, wb_we = 0). Latency is 1 cycle.
REQ-028 Lw (100011) or Sw (101011) with result[1:0] != 0: go to OUT with wb_exc = 10 and wb_we = 0; mem_req is never asserted.
REQ-029 Aligned Lw/Sw: go to REQ and assert mem_req, mem_we, mem_addr and mem_wdata, all stable until the cycle in which mem_gnt = 1.
REQ-030 In REQ, on mem_gnt: Sw goes to OUT (wb_we = 0); Lw goes to WAIT_RD. mem_rvalid seen in REQ is ignored.
REQ-031 In WAIT_RD, on mem_rvalid: capture mem_rdata into wb_data, wb_we = 1, go to OUT. The first wb_valid occurs the cycle after mem_rvalid.
REQ-032 The timeout counter SHALL clear on entering REQ or WAIT_RD and increment each cycle spent there. When it reaches TIMEOUT without the awaited event: go to OUT with wb_exc = 11, wb_we = 0, and drop mem_req.
REQ-033 In OUT, wb_valid = 1 and the record is held stable until wb_ready = 1. On wb_ready: with a simultaneous transfer, load the new op (REQ-026 to REQ-028 apply); otherwise go to IDLE.
REQ-034 wb_valid SHALL be 0 in every state except OUT; mem_req SHALL be 0 in every state except REQ.
REQ-035 wb_dest = registered dest for every record, including faulted records.

Reset
REQ-036 When rst is asserted, the stage SHALL immediately enter IDLE: mem_req, mem_we, wb_valid, wb_we = 0; wb_exc = 00; mem_addr, mem_wdata, wb_data, wb_dest, counter = 0.
REQ-037 Reset asserted in REQ or WAIT_RD SHALL abandon the access; a late mem_gnt or mem_rvalid after reset is ignored.
REQ-038 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-039 Addu, result 0x0000_0005, dest 3, wb_ready = 1 -> wb_valid one cycle later, wb_we = 1, wb_dest = 3, wb_data = 5, wb_exc = 00.
REQ-040 Lw, addr 0x100; mem_gnt after 2 cycles; mem_rvalid 3 cycles later with 0xDEADBEEF -> mem_req held 3 cycles; wb_data = 0xDEADBEEF, wb_we = 1.
REQ-041 Sw, addr 0x102 -> no mem_req; wb_exc = 10, wb_we = 0. Add with flags = 100 -> wb_exc = 01, wb_we = 0.
REQ-042 Lw, TIMEOUT = 4, mem_gnt never asserted -> mem_req for 4 cycles, then wb_exc = 11.
REQ-043 wb_ready low for 3 cycles in OUT -> record stable and in_ready = 0; back-to-back Addu ops with wb_ready = 1 -> one record per cycle.
REQ-044 rst asserted in WAIT_RD, then mem_rvalid -> outputs stay at reset values; wb_valid never asserts.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//
// This stage accepts one operation at a time from the ALU stage. Each operation
// takes one of three paths:
//   * ALU and branch ops pass straight through to a write-back record.
//   * Misaligned Lw/Sw ops fault at once and never touch the memory bus.
//   * Aligned Lw/Sw ops issue a request on the memory bus. A load then waits
//     for its read data.
// Every bus wait is bounded by TIMEOUT cycles. When the bound expires, the
// record carries a bus-timeout exception.
//
// Ports
//   clk, rst                         clock and asynchronous active-high reset
//   in_valid/in_ready                upstream handshake
//   in_opcode, in_result,            operation captured on transfer
//   in_store_data, in_dest, in_flags
//   mem_req/mem_we/mem_addr/         memory request, held until mem_gnt
//   mem_wdata, mem_gnt
//   mem_rvalid, mem_rdata            load data return
//   wb_valid/wb_ready                downstream handshake
//   wb_we, wb_dest, wb_data, wb_exc  write-back record
//                                    (wb_exc: 00 none, 01 ovf, 10 misaligned,
//                                     11 bus timeout)
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_dest,
  input  logic [2:0]  in_flags,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_exc
);

  // The counter only needs to hold 0..TIMEOUT-1. On the cycle it would reach
  // TIMEOUT, the wait is declared lost instead.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_OVF     = 2'b01;
  localparam logic [1:0] EXC_ALIGN   = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_we_q, wb_we_d;
  logic [4:0]    wb_dest_q, wb_dest_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [1:0]    wb_exc_q, wb_exc_d;

  logic is_lw, is_sw, is_branch, is_mem, misaligned, take;
  // Only the overflow flag affects this stage. The compare flags are unused.
  logic unused_flags;

  assign unused_flags = ^in_flags[1:0];
  assign is_lw        = (in_opcode == OP_LW);
  assign is_sw        = (in_opcode == OP_SW);
  assign is_branch    = (in_opcode == OP_BEQ) || (in_opcode == OP_BNE);
  assign is_mem       = is_lw || is_sw;
  assign misaligned   = (in_result[1:0] != 2'b00);

  // The stage can take a new op while idle. It can also take one in the same
  // cycle that the current record drains, so back-to-back ops stream at one
  // record per cycle.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && wb_ready);
  assign take     = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = wb_valid_q;
    wb_we_d     = wb_we_q;
    wb_dest_d   = wb_dest_q;
    wb_data_d   = wb_data_q;
    wb_exc_d    = wb_exc_q;

    case (state_q)
      S_IDLE: begin
      end
      S_REQ: begin
        // A grant wins over a timeout in the same cycle.
        // Any read-data strobe seen here is stale and is ignored.
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (mem_we_q) begin
            state_d    = S_OUT;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_exc_d   = EXC_NONE;
          end else begin
            state_d = S_WAIT_RD;
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d  = 1'b0;
          state_d    = S_OUT;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_exc_d   = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (mem_rvalid) begin
          state_d    = S_OUT;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b1;
          wb_data_d  = mem_rdata;
          wb_exc_d   = EXC_NONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = S_OUT;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_exc_d   = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        // If a new op arrives in the same cycle, the load below overrides this.
        if (wb_ready) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
          wb_we_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture a new op. This can happen from IDLE or from a draining OUT.
    if (take) begin
      wb_dest_d   = in_dest;
      wb_data_d   = in_result;
      mem_addr_d  = in_result;
      mem_wdata_d = in_store_data;
      mem_we_d    = is_sw;
      cnt_d       = '0;
      if (is_mem && misaligned) begin
        state_d    = S_OUT;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_we_d    = 1'b0;
        wb_exc_d   = EXC_ALIGN;
      end else if (is_mem) begin
        state_d    = S_REQ;
        mem_req_d  = 1'b1;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_exc_d   = EXC_NONE;
      end else begin
        state_d    = S_OUT;
        mem_req_d  = 1'b0;
        wb_valid_d = 1'b1;
        wb_we_d    = !(is_sw || is_branch || in_flags[2]);
        wb_exc_d   = in_flags[2] ? EXC_OVF : EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
      wb_exc_q    <= EXC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
      wb_exc_q    <= wb_exc_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;
  assign wb_exc    = wb_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// Expected write-back records, latencies and bus-request counts come from a
// behavioural model. The model applies the operation rules directly to each
// op and its chosen memory response delays.
module tb_mem_stage;

  localparam int TMO = 4;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDU = 6'b000000;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_opcode;
  logic [31:0] in_result, in_store_data;
  logic [4:0]  in_dest;
  logic [2:0]  in_flags;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_ready, wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [1:0]  wb_exc;

  int total = 0;
  int bad   = 0;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_result(in_result), .in_store_data(in_store_data), .in_dest(in_dest),
    .in_flags(in_flags),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_exc(wb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  exc;
    logic [31:0] data;
    bit          chk_data;
    int          lat;   // cycles from transfer edge until wb_valid is seen
    int          reqs;  // cycles with mem_req high
  } exp_t;

  // g = request cycles without grant before the grant, r = wait cycles
  // before read data. Any value >= TMO means the event never arrives in time.
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] res,
                                 input logic [2:0] flg, input int g, input int r,
                                 input logic [31:0] rd);
    exp_t e;
    logic [1:0] low;
    e.data = res; e.chk_data = 1'b1; e.reqs = 0; e.lat = 1; e.we = 1'b0; e.exc = 2'b00;
    low = res[1:0];
    if (op == OP_LW || op == OP_SW) begin
      if (low != 2'b00) begin
        e.exc = 2'b10; e.chk_data = 1'b0;
      end else if (g >= TMO) begin
        e.exc = 2'b11; e.chk_data = 1'b0; e.reqs = TMO; e.lat = TMO + 1;
      end else begin
        e.reqs = g + 1;
        if (op == OP_SW) begin
          e.chk_data = 1'b0; e.lat = g + 2;
        end else if (r >= TMO) begin
          e.exc = 2'b11; e.chk_data = 1'b0; e.lat = g + TMO + 2;
        end else begin
          e.we = 1'b1; e.data = rd; e.lat = g + r + 3;
        end
      end
    end else if (flg[2]) begin
      e.exc = 2'b01;
    end else begin
      e.we = !(op == OP_BEQ || op == OP_BNE);
    end
    return e;
  endfunction

  function automatic logic [5:0] pick_alu(input int k);
    case (k % 6)
      0: return OP_ADDU;
      1: return OP_BEQ;
      2: return OP_BNE;
      3: return 6'b001001;
      4: return 6'b001101;
      default: return 6'b001010;
    endcase
  endfunction

  task automatic garbage_inputs();
    in_opcode = 6'($urandom); in_result = $urandom; in_store_data = $urandom;
    in_dest = 5'($urandom); in_flags = 3'($urandom);
  endtask

  // Sends one op from IDLE and serves the memory side with the chosen delays.
  // It holds wb_ready low for `stall` cycles, then drains the record.
  task automatic run_op(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                        input logic [4:0] dst, input logic [2:0] flg, input int g, input int r,
                        input logic [31:0] rd, input int stall);
    exp_t e;
    int n, reqs, gnt_at;
    bit seen, v, q;
    logic [31:0] held;
    e = model(op, res, flg, g, r, rd);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_result = res; in_store_data = sd;
    in_dest = dst; in_flags = flg; wb_ready = 1'($urandom);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL accept: in_ready=%b required 1", in_ready);
    end
    reqs = 0; gnt_at = 0; seen = 1'b0; n = 0; held = '0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      n = c; v = wb_valid; q = mem_req;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (v === 1'b1) begin
        seen = 1'b1; held = wb_data;
        in_valid = 1'b0; wb_ready = 1'b0;
      end else begin
        in_valid = 1'($urandom); garbage_inputs(); wb_ready = 1'($urandom);
        if (q === 1'b1) begin
          reqs++;
          total++;
          if (mem_addr !== res || mem_we !== (op == OP_SW) || mem_wdata !== sd) begin
            bad++;
            $display("FAIL req_fields: addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, res, (op == OP_SW), sd);
          end
          if (reqs == g + 1) begin mem_gnt = 1'b1; gnt_at = c; end
          mem_rvalid = 1'($urandom);  // stray strobes in REQ must be ignored
        end else if (gnt_at > 0 && (c - gnt_at) == r + 1) begin
          mem_rvalid = 1'b1; mem_rdata = rd;
        end
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++;
    if (!seen || n != e.lat) begin
      bad++; $display("FAIL latency: got %0d (seen=%0d) required %0d", n, seen, e.lat);
    end
    total++;
    if (reqs != e.reqs) begin
      bad++; $display("FAIL req_cycles: got %0d required %0d", reqs, e.reqs);
    end
    total++;
    if (wb_we !== e.we || wb_exc !== e.exc || wb_dest !== dst ||
        (e.chk_data && wb_data !== e.data)) begin
      bad++;
      $display("FAIL record: we=%b exc=%b dest=%0d data=%h required we=%b exc=%b dest=%0d data=%h",
               wb_we, wb_exc, wb_dest, wb_data, e.we, e.exc, dst, e.data);
    end
    $display("txn op=%b res=%h dest=%0d g=%0d r=%0d -> we=%b exc=%b data=%h lat=%0d reqs=%0d",
             op, res, dst, g, r, wb_we, wb_exc, wb_data, n, reqs);
    for (int s = 0; s < stall; s++) begin
      wb_ready = 1'b0; in_valid = 1'b1; garbage_inputs();
      #1;
      total++;
      if (in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_ready: in_ready=%b required 0", in_ready);
      end
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b1 || wb_we !== e.we || wb_exc !== e.exc || wb_dest !== dst || wb_data !== held) begin
        bad++;
        $display("FAIL stall_hold: valid=%b we=%b exc=%b dest=%0d data=%h required 1 %b %b %0d %h",
                 wb_valid, wb_we, wb_exc, wb_dest, wb_data, e.we, e.exc, dst, held);
      end
    end
    wb_ready = 1'b1; in_valid = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL drain_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL drain_idle: wb_valid=%b mem_req=%b required 0 0", wb_valid, mem_req);
    end
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_result = '0; in_store_data = '0;
    in_dest = '0; in_flags = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: req=%b we=%b wb_valid=%b wb_we=%b required all 0",
                      mem_req, mem_we, wb_valid, wb_we);
    end
    total++;
    if (wb_exc !== 2'b00 || wb_dest !== 5'd0 || wb_data !== 32'd0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_data: exc=%b dest=%0d data=%h addr=%h wdata=%h required zeros",
                      wb_exc, wb_dest, wb_data, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_directed();
    run_op(OP_ADDU, 32'h0000_0005, 32'h0, 5'd3, 3'b000, 0, 0, 32'h0, 0);
    run_op(OP_LW, 32'h0000_0100, 32'h1234_5678, 5'd7, 3'b000, 2, 2, 32'hDEAD_BEEF, 0);
    run_op(OP_SW, 32'h0000_0102, 32'hAAAA_5555, 5'd4, 3'b000, 0, 0, 32'h0, 0);
    run_op(OP_ADDU, 32'h7FFF_FFFF, 32'h0, 5'd5, 3'b100, 0, 0, 32'h0, 0);
    run_op(OP_LW, 32'h0000_0200, 32'h0, 5'd6, 3'b000, 100, 0, 32'h0, 0);
    run_op(OP_LW, 32'h0000_0300, 32'h0, 5'd8, 3'b000, 1, 100, 32'h0, 1);
    run_op(OP_SW, 32'h0000_0400, 32'h0BAD_F00D, 5'd9, 3'b000, TMO - 1, 0, 32'h0, 0);
  endtask

  task automatic test_stall();
    run_op(OP_ADDU, 32'h0000_0042, 32'h0, 5'd12, 3'b000, 0, 0, 32'h0, 3);
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops[8];
    logic [31:0] res[8];
    logic [4:0]  dst[8];
    logic [2:0]  flg[8];
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      ops[i] = (i < 4) ? OP_ADDU : pick_alu(int'($urandom_range(0, 5)));
      res[i] = $urandom; dst[i] = 5'($urandom); flg[i] = 3'($urandom);
    end
    @(negedge clk);
    wb_ready = 1'b1; in_valid = 1'b1;
    in_opcode = ops[0]; in_result = res[0]; in_dest = dst[0]; in_flags = flg[0];
    in_store_data = $urandom;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = model(ops[k-1], res[k-1], flg[k-1], 0, 0, 32'h0);
      total++;
      if (wb_valid !== 1'b1 || wb_we !== e.we || wb_exc !== e.exc ||
          wb_dest !== dst[k-1] || wb_data !== e.data) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b we=%b exc=%b dest=%0d data=%h required 1 %b %b %0d %h",
                 k - 1, wb_valid, wb_we, wb_exc, wb_dest, wb_data, e.we, e.exc, dst[k-1], e.data);
      end
      $display("txn b2b op=%b dest=%0d -> we=%b exc=%b data=%h", ops[k-1], dst[k-1], wb_we, wb_exc, wb_data);
      if (k < 8) begin
        in_opcode = ops[k]; in_result = res[k]; in_dest = dst[k]; in_flags = flg[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready_%0d: in_ready=%b required 1", k, in_ready);
      end
    end
    @(negedge clk);
    total++;
    if (wb_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end: wb_valid=%b required 0", wb_valid);
    end
    wb_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] res;
    int k;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 5));
      case (k)
        0: op = OP_LW;
        1: op = OP_SW;
        default: op = pick_alu(int'($urandom_range(0, 5)));
      endcase
      res = $urandom;
      if ($urandom_range(0, 3) != 0) res = {res[31:2], 2'b00};
      run_op(op, res, $urandom, 5'($urandom), 3'($urandom),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom,
             int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_in_wait_rd();
    @(negedge clk);
    wb_ready = 1'b0; in_valid = 1'b1; in_opcode = OP_LW; in_result = 32'h0000_0200;
    in_store_data = 32'h0; in_dest = 5'd9; in_flags = 3'b000;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL rst_wait_req: mem_req=%b required 1", mem_req);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    total++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rst_wait_state: mem_req=%b wb_valid=%b required 0 0", mem_req, wb_valid);
    end
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    total++;
    if (mem_addr !== 32'd0 || wb_dest !== 5'd0 || wb_valid !== 1'b0 || wb_data !== 32'd0) begin
      bad++; $display("FAIL rst_async: addr=%h dest=%0d valid=%b data=%h required zeros",
                      mem_addr, wb_dest, wb_valid, wb_data);
    end
    @(negedge clk);
    rst = 1'b0; mem_gnt = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready: in_ready=%b required 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (wb_valid !== 1'b0 || wb_data !== 32'd0 || mem_req !== 1'b0 || wb_we !== 1'b0) begin
        bad++; $display("FAIL rst_late_rvalid_%0d: valid=%b data=%h req=%b we=%b required 0",
                        c, wb_valid, wb_data, mem_req, wb_we);
      end
    end
    $display("txn reset-in-wait_rd -> wb_valid=%b wb_data=%h", wb_valid, wb_data);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_in_wait_rd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
